// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
//   Shares one multi-cycle floating-point adder among NUM_REQ requesters.
//   Operand pairs are granted round-robin, handed to the adder with a
//   one-cycle start pulse, and the sum is returned on a single response
//   channel tagged with the owning requester id. One op is in flight at a
//   time.
//
//   Optional feature: define FP_ARB_TIMEOUT_EN to add a WAIT-state watchdog.
//   If the adder gives no add_done within TIMEOUT cycles, the op completes
//   with a quiet NaN and rsp_err=1. Without the macro WAIT is unbounded and
//   rsp_err is tied to 0.
//
// Ports
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   req_valid   per-requester operand valid             [NUM_REQ]
//   req_a/req_b packed operands, lane i at [32i+31:32i] [NUM_REQ*32]
//   req_ready   one-hot accept strobe (IDLE only)       [NUM_REQ]
//   add_a/add_b latched operands to the adder           [32]
//   add_start   one-cycle start pulse to the adder
//   add_done    adder result valid pulse
//   add_result  adder sum                               [32]
//   rsp_valid   response valid
//   rsp_id      requester that owns the response        [ID_W]
//   rsp_result  sum                                     [32]
//   rsp_err     watchdog abort flag
//   rsp_ready   response consumer ready
//   busy        high whenever the FSM is not IDLE
//   ops_count   completed-response counter, wraps       [16]

module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  output logic                   add_start,
  input  logic                   add_done,
  input  logic [31:0]            add_result,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_result,
  output logic                   rsp_err,
  input  logic                   rsp_ready,
  output logic                   busy,
  output logic [15:0]            ops_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [1:0]         state;
  logic [ID_W-1:0]    rr_ptr;       // last requester served
  logic [ID_W-1:0]    grant;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [NUM_REQ-1:0] cand;
  logic               grant_found;

  // Round-robin search starting just after the last served requester, so the
  // lane served most recently is considered last.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant        = '0;
    grant_onehot = '0;
    grant_found  = 1'b0;
    cand         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = NUM_REQ'(1) << ((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && |(req_valid & cand)) begin
        grant_found  = 1'b1;
        grant        = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        grant_onehot = cand;
      end
    end
  end

  // Gated by reset_n so every output reads 0 while reset is held.
  assign req_ready = (state == IDLE && reset_n) ? grant_onehot : '0;
  assign add_start = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

`ifdef FP_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // Cleared while in ISSUE so it reads 0 on the first WAIT cycle; expiry
  // falls on the TIMEOUT-th WAIT cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign rsp_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      add_a      <= '0;
      add_b      <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      ops_count  <= '0;
`ifdef FP_ARB_TIMEOUT_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            add_a  <= 32'(req_a >> (32 * grant));
            add_b  <= 32'(req_b >> (32 * grant));
            rsp_id <= grant;
            rr_ptr <= grant;
            state  <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // A done pulse wins over a simultaneous watchdog expiry.
          if (add_done) begin
            rsp_result <= add_result;
`ifdef FP_ARB_TIMEOUT_EN
            rsp_err    <= 1'b0;
`endif
            state      <= RESP;
          end
`ifdef FP_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            rsp_result <= QNAN;
            rsp_err    <= 1'b1;
            state      <= RESP;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            ops_count <= ops_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
